// File: rtl/alu_req_seq.sv
// ============================================================================
// Module   : alu_req_seq
// Brief    : Initiator for a 4-bit combinational ALU. Accepts requests over a
//            valid/ready handshake, drives registered operands/opcode to the
//            ALU, waits SETTLE cycles, captures alu_y and returns it over a
//            second valid/ready handshake. Divide/modulo by zero is trapped
//            locally and answered with 0xFF and rsp_err=1.
// Options  : define ALU_REQ_SEQ_STATS_EN to add stat_ops/stat_errs counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_req_seq #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [2:0] req_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_err,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [7:0] alu_y,
    output logic       busy
`ifdef ALU_REQ_SEQ_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_errs
`endif
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);
    localparam logic [7:0] c_trap_y      = 8'hFF;
    localparam logic [2:0] c_op_div      = 3'b011;
    localparam logic [2:0] c_op_mod      = 3'b110;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_s;
    logic [7:0] r_rsp_y;
    logic       r_rsp_err;

    logic w_accept;
    logic w_trap;
    logic w_settled;
    logic w_rsp_hs;

    assign w_accept  = (r_state == c_st_idle) && req_valid;
    assign w_trap    = ((req_op == c_op_div) || (req_op == c_op_mod)) && (req_b == 4'd0);
    assign w_settled = (r_state == c_st_drive) && (r_cnt == 4'd0);
    assign w_rsp_hs  = (r_state == c_st_resp) && rsp_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    w_state_next = w_trap ? c_st_resp : c_st_drive;
                end
            end
            c_st_drive: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = c_st_resp;
                end
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Handshake outputs; req_ready is masked during reset
    always_comb begin
        req_ready = (r_state == c_st_idle) && !rst;
        rsp_valid = (r_state == c_st_resp);
        busy      = (r_state != c_st_idle);
    end

    // Operand/opcode capture, settle counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= 4'd0;
            r_alu_b   <= 4'd0;
            r_alu_s   <= 3'd0;
            r_cnt     <= 4'd0;
            r_rsp_y   <= 8'h00;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_trap) begin
                    // ALU is never asked to divide by zero; its inputs stay put
                    r_rsp_y   <= c_trap_y;
                    r_rsp_err <= 1'b1;
                end else begin
                    r_alu_a <= req_a;
                    r_alu_b <= req_b;
                    r_alu_s <= req_op;
                    r_cnt   <= c_settle_load;
                end
            end else if (w_settled) begin
                r_rsp_y   <= alu_y;
                r_rsp_err <= 1'b0;
            end else if (r_state == c_st_drive) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_s   = r_alu_s;
    assign rsp_y   = r_rsp_y;
    assign rsp_err = r_rsp_err;

`ifdef ALU_REQ_SEQ_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_errs;

    // Saturating completion counters, stepped on the response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ops  <= 16'd0;
            r_stat_errs <= 16'd0;
        end else if (w_rsp_hs) begin
            if (r_stat_ops != 16'hFFFF) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if (r_rsp_err && (r_stat_errs != 16'hFFFF)) begin
                r_stat_errs <= r_stat_errs + 16'd1;
            end
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_rsp_hs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_req_seq.sv
// ============================================================================
// Module   : tb_alu_req_seq
// Brief    : Scoreboard bench for alu_req_seq. Two instances (SETTLE=1 and
//            SETTLE=4), each with a behavioural ALU model on its alu_* port.
//            Stimulus pushes expected {err,y} into a per-instance queue; a
//            monitor per instance pops and compares on each response
//            handshake. Stats ports are checked when ALU_REQ_SEQ_STATS_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_req_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = 4'd0;
    logic [3:0] req_b = 4'd0;
    logic [2:0] req_op = 3'd0;
    logic       rsp_ready = 1'b0;

    logic       req_valid1 = 1'b0, req_ready1, rsp_valid1, rsp_err1, busy1;
    logic [7:0] rsp_y1, alu_y1;
    logic [3:0] alu_a1, alu_b1;
    logic [2:0] alu_s1;

    logic       req_valid4 = 1'b0, req_ready4, rsp_valid4, rsp_err4, busy4;
    logic [7:0] rsp_y4, alu_y4;
    logic [3:0] alu_a4, alu_b4;
    logic [2:0] alu_s4;

`ifdef ALU_REQ_SEQ_STATS_EN
    logic [15:0] stat_ops1, stat_errs1, stat_ops4, stat_errs4;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] q1[$];
    logic [8:0] q4[$];

    always #5 clk = ~clk;

    // Reference model of the external combinational ALU
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
        logic [7:0] ea, eb;
        ea = {4'd0, a};
        eb = {4'd0, b};
        case (s)
            3'd0: return ea + eb;
            3'd1: return ea - eb;
            3'd2: return ea * eb;
            3'd3: return (b == 4'd0) ? 8'h00 : ea / eb;
            3'd4: return {4'd0, a ^ b};
            3'd5: return {4'd0, ~(a & b)};
            3'd6: return (b == 4'd0) ? 8'h00 : ea % eb;
            default: return 8'd0 - ea;
        endcase
    endfunction

    assign alu_y1 = alu_f(alu_a1, alu_b1, alu_s1);
    assign alu_y4 = alu_f(alu_a4, alu_b4, alu_s4);

    alu_req_seq #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y1), .rsp_err(rsp_err1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_y(alu_y1),
        .busy(busy1)
`ifdef ALU_REQ_SEQ_STATS_EN
        , .stat_ops(stat_ops1), .stat_errs(stat_errs1)
`endif
    );

    alu_req_seq #(.SETTLE(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y4), .rsp_err(rsp_err4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_s(alu_s4), .alu_y(alu_y4),
        .busy(busy4)
`ifdef ALU_REQ_SEQ_STATS_EN
        , .stat_ops(stat_ops4), .stat_errs(stat_errs4)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a response is taken at the next rising edge when valid&ready
    initial forever begin
        @(negedge clk); #1;
        if (rsp_valid1 && rsp_ready) begin
            if (q1.size() == 0) check("dut1_unexpected_rsp", {rsp_err1, rsp_y1}, 9'h000);
            else check("dut1_rsp", {rsp_err1, rsp_y1}, q1.pop_front());
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (rsp_valid4 && rsp_ready) begin
            if (q4.size() == 0) check("dut4_unexpected_rsp", {rsp_err4, rsp_y4}, 9'h000);
            else check("dut4_rsp", {rsp_err4, rsp_y4}, q4.pop_front());
        end
    end

    // Issue one request to dut1; lat counts edges from the accept edge
    // (inclusive) to the first cycle with rsp_valid=1.
    task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input logic [8:0] exp, output int lat);
        int n = 0;
        while (!req_ready1 && n < 50) begin @(negedge clk); n++; end
        check("dut1_ready_wait", req_ready1, 1'b1);
        req_a = a; req_b = b; req_op = op; req_valid1 = 1'b1;
        q1.push_back(exp);
        @(negedge clk);
        req_valid1 = 1'b0;
        lat = 1;
        while (!rsp_valid1 && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input logic [8:0] exp, input bit push);
        int n = 0;
        while (!req_ready4 && n < 50) begin @(negedge clk); n++; end
        check("dut4_ready_wait", req_ready4, 1'b1);
        req_a = a; req_b = b; req_op = op; req_valid4 = 1'b1;
        if (push) q4.push_back(exp);
        @(negedge clk);
        req_valid4 = 1'b0;
    endtask

    task automatic wait_idle1();
        int n = 0;
        while ((busy1 || rsp_valid1) && n < 50) begin @(negedge clk); n++; end
        check("dut1_idle_wait", busy1, 1'b0);
    endtask

    initial begin
        int lat;
        int nvalid;
        // ---- reset state ----
        @(negedge clk);
        check("reset_req_ready", {req_ready1, req_ready4}, 2'b00);
        check("reset_outputs", {rsp_valid1, busy1, rsp_err1, rsp_y1, alu_a1, alu_b1, alu_s1}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {req_ready1, busy1}, 2'b10);
        rsp_ready = 1'b1;

        // ---- add, SETTLE=1 ----
        issue1(4'd5, 4'd3, 3'b000, {1'b0, 8'h08}, lat);
        check("add_alu_regs", {alu_a1, alu_b1, alu_s1}, {4'd5, 4'd3, 3'b000});
        check("add_latency", lat, 2);
        check("add_busy_no_ready", {busy1, req_ready1}, 2'b10);
        wait_idle1();

        // ---- divide / modulo by zero ----
        issue1(4'd9, 4'd0, 3'b011, {1'b1, 8'hFF}, lat);
        check("div0_latency", lat, 1);
        check("div0_alu_kept", {alu_a1, alu_b1, alu_s1}, {4'd5, 4'd3, 3'b000});
        wait_idle1();
        issue1(4'd9, 4'd0, 3'b110, {1'b1, 8'hFF}, lat);
        check("mod0_latency", lat, 1);
        check("mod0_alu_kept", {alu_a1, alu_b1, alu_s1}, {4'd5, 4'd3, 3'b000});
        wait_idle1();

        // ---- assorted opcodes ----
        issue1(4'hA, 4'h6, 3'b100, {1'b0, 8'h0C}, lat);   // xor
        issue1(4'hC, 4'hA, 3'b101, {1'b0, 8'h07}, lat);   // nand (4-bit, zero-extended)
        issue1(4'd13, 4'd4, 3'b011, {1'b0, 8'h03}, lat);  // div
        issue1(4'd13, 4'd4, 3'b110, {1'b0, 8'h01}, lat);  // mod
        issue1(4'd3, 4'd9, 3'b111, {1'b0, 8'hFD}, lat);   // negate
        check("neg_alu_b_loaded", {alu_a1, alu_b1, alu_s1}, {4'd3, 4'd9, 3'b111});
        wait_idle1();

        // ---- backpressure ----
        rsp_ready = 1'b0;
        issue1(4'd15, 4'd15, 3'b010, {1'b0, 8'hE1}, lat);
        check("mul_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp_valid1, req_ready1, rsp_err1, rsp_y1}, {1'b1, 1'b0, 1'b0, 8'hE1});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {rsp_valid1, req_ready1, rsp_y1}, {1'b0, 1'b1, 8'hE1});

        // ---- SETTLE=4, inputs wiggled during DRIVE ----
        issue4(4'd2, 4'd7, 3'b001, {1'b0, 8'hFB}, 1'b1);
        lat = 1;
        while (!rsp_valid4 && lat < 40) begin
            req_a = 4'hF; req_b = 4'h1; req_op = 3'(lat);
            @(negedge clk); lat++;
        end
        check("settle4_latency", lat, 5);
        check("settle4_alu_stable", {alu_a4, alu_b4, alu_s4}, {4'd2, 4'd7, 3'b001});
        @(negedge clk);

        // ---- asynchronous reset during DRIVE ----
        issue4(4'd1, 4'd1, 3'b000, 9'h000, 1'b0);
        @(negedge clk);
        check("pre_reset_busy", busy4, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_dut4", {busy4, rsp_valid4, req_ready4, alu_a4, alu_b4, rsp_y4}, 0);
        check("async_reset_dut1", {busy1, req_ready1, alu_a1, rsp_y1}, 0);
`ifdef ALU_REQ_SEQ_STATS_EN
        check("stats_reset", {stat_ops1, stat_errs1}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid4) nvalid++;
        end
        check("no_stale_rsp", nvalid, 0);
        issue4(4'd6, 4'd2, 3'b010, {1'b0, 8'h0C}, 1'b1);
        lat = 1;
        while (!rsp_valid4 && lat < 40) begin @(negedge clk); lat++; end
        check("post_reset_latency", lat, 5);
        @(negedge clk);

`ifdef ALU_REQ_SEQ_STATS_EN
        // ---- statistics: 3 good + 2 trapped on dut1 ----
        issue1(4'd1, 4'd2, 3'b000, {1'b0, 8'h03}, lat);
        issue1(4'd7, 4'd0, 3'b011, {1'b1, 8'hFF}, lat);
        issue1(4'd4, 4'd4, 3'b010, {1'b0, 8'h10}, lat);
        issue1(4'd2, 4'd0, 3'b110, {1'b1, 8'hFF}, lat);
        issue1(4'd8, 4'd1, 3'b001, {1'b0, 8'h07}, lat);
        wait_idle1();
        check("stat_ops", stat_ops1, 16'd5);
        check("stat_errs", stat_errs1, 16'd2);
        rst = 1'b1;
        @(negedge clk);
        check("stats_cleared", {stat_ops1, stat_errs1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
`endif

        // ---- drain ----
        for (int i = 0; i < 20 && (q1.size() + q4.size()) != 0; i++) @(negedge clk);
        check("scoreboard_drained", q1.size() + q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
